// File: rtl/rect_fill_drawer.sv
// Solid-colour rectangle rasteriser: clips one request to the visible screen and
// emits one registered pixel write per clock, followed by a one-cycle done pulse.
module rect_fill_drawer #(
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  width,
  input  logic [6:0]  height,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [23:0] VGA_COLOR,
  output logic        plot
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [8:0] X_LAST = 9'(X_MAX);
  localparam logic [8:0] Y_LAST = 9'(Y_MAX);

  state_t      state_q, state_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [23:0] color_q, color_d;
  logic [8:0]  ew_q, ew_d;
  logic [8:0]  eh_q, eh_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        plot_q, plot_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [23:0] vga_c_q, vga_c_d;

  logic [8:0]  x_room, y_room;
  logic [8:0]  ew_c, eh_c;
  logic        last_col, last_row;

  // Clipped extent of the incoming request, in 9 bits so X_MAX+1 cannot wrap.
  always_comb begin
    x_room = X_LAST + 9'd1 - {1'b0, x0};
    y_room = Y_LAST + 9'd1 - {2'b00, y0};
    if ({1'b0, x0} > X_LAST)
      ew_c = '0;
    else if ({1'b0, width} < x_room)
      ew_c = {1'b0, width};
    else
      ew_c = x_room;
    if ({2'b00, y0} > Y_LAST)
      eh_c = '0;
    else if ({2'b00, height} < y_room)
      eh_c = {2'b00, height};
    else
      eh_c = y_room;
  end

  assign last_col = ({1'b0, cx_q} == (ew_q - 9'd1));
  assign last_row = ({2'b00, cy_q} == (eh_q - 9'd1));

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    color_d = color_q;
    ew_d    = ew_q;
    eh_d    = eh_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    vga_x_d = vga_x_q;
    vga_y_d = vga_y_q;
    vga_c_d = vga_c_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          color_d = color;
          ew_d    = ew_c;
          eh_d    = eh_c;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (ew_c != '0 && eh_c != '0) ? S_DRAW : S_DONE;
        end
      end
      S_DRAW: begin
        plot_d  = 1'b1;
        vga_x_d = x0_q + cx_q;
        vga_y_d = y0_q + cy_q;
        vga_c_d = color_q;
        if (last_col) begin
          cx_d = '0;
          if (last_row)
            state_d = S_DONE;
          else
            cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      color_q <= '0;
      ew_q    <= '0;
      eh_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      color_q <= color_d;
      ew_q    <= ew_d;
      eh_q    <= eh_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign VGA_X     = vga_x_q;
  assign VGA_Y     = vga_y_q;
  assign VGA_COLOR = vga_c_q;

endmodule

// File: doc/rect_fill_drawer.md
# rect_fill_drawer

Rectangle fill engine that rasterises one axis-aligned, solid-colour rectangle into the pixel-write stream consumed by the VGA adapter: `VGA_X`, `VGA_Y`, `VGA_COLOR` and `plot`. It sits directly upstream of the VGA output of `top` and draws piano keys, key-press highlights and background panels. A requester issues one `start` with geometry and colour. The block emits one pixel per clock, clips to the 160x120 screen, and pulses `done`.

## Interface

Parameters:
- `X_MAX`, 159, last visible column
- `Y_MAX`, 119, last visible row

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge
- `resetn`  in  1  synchronous, active-low reset, sampled on `CLOCK_50`
- `start`  in  1  request; accepted only in IDLE
- `x0`  in  8  left column
- `y0`  in  7  top row
- `width`  in  8  columns, 0..255
- `height`  in  7  rows, 0..127
- `color`  in  24  RGB888 fill colour
- `busy`  out  1  high while a request is in progress, including the `done` cycle
- `done`  out  1  one-cycle completion pulse
- `VGA_X`  out  8  pixel column
- `VGA_Y`  out  7  pixel row
- `VGA_COLOR`  out  24  pixel colour
- `plot`  out  1  pixel write strobe; X/Y/COLOR are valid when high

## Operation

- States are IDLE, DRAW and DONE. All outputs are registered.
- **IDLE, with `start`=1:**
  - Latch `x0`, `y0` and `color`.
  - Compute the effective width and height in 9-bit arithmetic:
    - `ew` = 0 if `x0` > X_MAX, else min(`width`, X_MAX+1-`x0`).
    - `eh` = 0 if `y0` > Y_MAX, else min(`height`, Y_MAX+1-`y0`).
  - Clear the column counter `cx` and the row counter `cy`.
  - Go to DRAW if `ew`≠0 and `eh`≠0; otherwise go to DONE.
- **DRAW, once per cycle:**
  - Drive `VGA_X` = `x0`+`cx`, `VGA_Y` = `y0`+`cy`, `VGA_COLOR` = latched `color`, `plot`=1.
  - Raster order: `cx` is the inner loop, `cy` the outer.
  - If `cx`=`ew`-1, wrap `cx` to 0 and increment `cy`.
  - After the pixel (`ew`-1, `eh`-1), go to DONE.
  - Clipping guarantees coordinates never exceed X_MAX/Y_MAX, so there is no 8/7-bit overflow.
- **DONE:** `done`=1 and `plot`=0 for one cycle, then return to IDLE.
- **`start` outside IDLE** (DRAW, DONE) is ignored. It is not queued.
- **`start` held high continuously:** a new request is accepted on the first IDLE cycle.
- **Inputs during a fill:** changes to `x0`, `y0`, `width`, `height` and `color` have no effect.
- **When `plot`=0:** `VGA_X`, `VGA_Y` and `VGA_COLOR` hold their last values.
- **Reset (`resetn`=0 at a clock edge), including mid-fill:**
  - State goes to IDLE.
  - `plot`, `busy`, `done`, `VGA_X`, `VGA_Y` and `VGA_COLOR` all go to 0.
  - The fill is abandoned and no `done` is issued.

## Timing

- Let N = `ew`·`eh`, and let edge k be the edge that samples `start`=1 in IDLE.
- `busy`=1 from after edge k until after edge k+N+2, when it falls.
- `plot`=1 after each of edges k+1 … k+N: N contiguous cycles with no gaps, one pixel per cycle.
- `done`=1 only after edge k+N+1.
- **Degenerate case (N=0):**
  - No `plot`.
  - `done` after edge k+1.
  - `busy` low after edge k+2.
- **Minimum request spacing:** the next `start` is accepted no earlier than edge k+N+2. Throughput is N+2 cycles per rectangle.
- **Downstream stall:** none. The VGA adapter accepts one write per cycle.

## Test plan

- **Basic fill:** reset, then `start` with x0=10, y0=20, width=3, height=2, color=FFFFFF.
  - -> 6 consecutive `plot` cycles at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all with VGA_COLOR=FFFFFF.
  - -> `done` on the next cycle; `busy` low one cycle later.
- **Clipping:** x0=158, y0=119, width=5, height=3, color=FF0000.
  - -> exactly 2 plots, (158,119) and (159,119).
  - -> `done` follows; no coordinate exceeds 159/119.
- **Degenerate requests:** width=0 (any height); then x0=200, width=4, height=4.
  - -> zero `plot` cycles in each case.
  - -> `done` one cycle after `start`; `busy` high for exactly 2 cycles.
- **Ignored start:** 4x4 fill at (0,0); mid-fill, pulse `start` with a different geometry and colour 00FF00, and change the inputs.
  - -> exactly 16 plots of the original colour in raster order.
  - -> no second fill.
- **Back-to-back:** hold `start`=1 for a 2x1 fill.
  - -> plots at (x0,y0) and (x0+1,y0), then `done`.
  - -> a second identical fill starts on the edge after the return to IDLE, so its first `plot` occurs 2 cycles after the first fill's `done`.
- **Reset mid-fill:** 10x10 fill; assert `resetn`=0 for one cycle after the 37th plot.
  - -> after that edge, `plot`, `busy`, `done`, `VGA_X`, `VGA_Y` and `VGA_COLOR` are all 0.
  - -> no `done` pulse; a new `start` then behaves normally.
